// File: rtl/spi_engine_if.sv
// Register-block side of the SPI engine: control/status registers and FIFO strobes.
// master = register block, slave = shift engine.
interface spi_engine_if;
  logic [7:0] spcr;
  logic [7:0] sper;
  logic       wfwe;
  logic [7:0] wfdin;
  logic       rfre;
  logic       wr_spsr;
  logic       clear_spif;
  logic       clear_wcol;
  logic [7:0] rfdout;
  logic [7:0] spsr;
  logic       spi_int;
  logic       busy;

  modport master (
    output spcr, sper, wfwe, wfdin, rfre, wr_spsr, clear_spif, clear_wcol,
    input  rfdout, spsr, spi_int, busy
  );

  modport slave (
    input  spcr, sper, wfwe, wfdin, rfre, wr_spsr, clear_spif, clear_wcol,
    output rfdout, spsr, spi_int, busy
  );
endinterface

// File: rtl/spi_engine.sv
// SPI master shift engine with write/read FIFOs, divider and SPSR status.
// Optional LSB-first transfers are enabled by defining SPI_LSB_FIRST_EN.
//
// state | meaning
// IDLE  | waiting for SPE & MSTR & write FIFO not empty
// LOAD  | pop write FIFO into shift register, reload divider
// SHIFT | 16 SCLK edges, one every half-period
// DONE  | push received byte, update transfer counter / SPIF
module spi_engine #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  spi_engine_if.slave bus,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  logic       spie, spe, mstr, cpol, cpha;
  logic [1:0] spr, espr, icnt;
  logic [3:0] sel, sel_c;
  logic [11:0] half, half_m1;
  logic       lsbfe;
  logic       unused_bits;

  assign spie = bus.spcr[7];
  assign spe  = bus.spcr[6];
  assign mstr = bus.spcr[4];
  assign cpol = bus.spcr[3];
  assign cpha = bus.spcr[2];
  assign spr  = bus.spcr[1:0];
  assign icnt = bus.sper[7:6];
  assign espr = bus.sper[1:0];

`ifdef SPI_LSB_FIRST_EN
  assign lsbfe       = bus.spcr[5];
  assign unused_bits = ^bus.sper[5:2];
`else
  assign lsbfe       = 1'b0;
  assign unused_bits = ^{bus.sper[5:2], bus.spcr[5]};
`endif

  assign sel     = {espr, spr};
  assign sel_c   = (sel > 4'd11) ? 4'd11 : sel;
  assign half    = 12'd1 << sel_c;
  assign half_m1 = half - 12'd1;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // write FIFO
  logic [7:0]  wf_mem [FIFO_DEPTH];
  logic [AW-1:0] wf_rd, wf_wr;
  logic [AW:0] wf_cnt;
  logic        wf_full, wf_empty, wf_push, wf_pop, wcol_set;

  assign wf_full  = (wf_cnt == DEPTH_C);
  assign wf_empty = (wf_cnt == '0);
  assign wf_pop   = (state_q == LOAD);
  // a push into a full FIFO is still accepted when the engine pops the same cycle
  assign wf_push  = bus.wfwe && (!wf_full || wf_pop);
  assign wcol_set = bus.wfwe && wf_full && !wf_pop;

  always_ff @(posedge clk) begin
    if (reset || !spe) begin
      wf_rd  <= '0;
      wf_wr  <= '0;
      wf_cnt <= '0;
    end else begin
      if (wf_push) wf_wr <= wf_wr + 1'b1;
      if (wf_pop)  wf_rd <= wf_rd + 1'b1;
      case ({wf_push, wf_pop})
        2'b10:   wf_cnt <= wf_cnt + 1'b1;
        2'b01:   wf_cnt <= wf_cnt - 1'b1;
        default: wf_cnt <= wf_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wf_push) wf_mem[wf_wr] <= bus.wfdin;
  end

  // read FIFO
  logic [7:0]  rf_mem [FIFO_DEPTH];
  logic [AW-1:0] rf_rd, rf_wr;
  logic [AW:0] rf_cnt;
  logic        rf_full, rf_empty, rf_push, rf_pop;
  logic [7:0]  rx_sr, rx_byte;
  logic        lsb_q;

  assign rf_full  = (rf_cnt == DEPTH_C);
  assign rf_empty = (rf_cnt == '0);
  assign rf_pop   = bus.rfre && !rf_empty;
  assign rf_push  = (state_q == DONE) && (!rf_full || rf_pop);
  assign rx_byte  = lsb_q ? rev8(rx_sr) : rx_sr;

  always_ff @(posedge clk) begin
    if (reset || !spe) begin
      rf_rd  <= '0;
      rf_wr  <= '0;
      rf_cnt <= '0;
    end else begin
      if (rf_push) rf_wr <= rf_wr + 1'b1;
      if (rf_pop)  rf_rd <= rf_rd + 1'b1;
      case ({rf_push, rf_pop})
        2'b10:   rf_cnt <= rf_cnt + 1'b1;
        2'b01:   rf_cnt <= rf_cnt - 1'b1;
        default: rf_cnt <= rf_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rf_push) rf_mem[rf_wr] <= rx_byte;
  end

  // FSM
  logic [11:0] div_cnt;
  logic [3:0]  edge_cnt;
  logic        div_zero;

  assign div_zero = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (spe && mstr && !wf_empty) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (div_zero && edge_cnt == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!spe) state_d = IDLE;
  end

  // shift datapath
  logic [7:0] tx_sr, tx_load;
  logic       leading, sample_edge;

  assign tx_load     = lsbfe ? rev8(wf_mem[wf_rd]) : wf_mem[wf_rd];
  assign leading     = ~edge_cnt[0];
  assign sample_edge = leading ^ cpha;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      lsb_q    <= 1'b0;
    end else if (!spe) begin
      sclk     <= cpol;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          sclk     <= cpol;
          div_cnt  <= half_m1;
          edge_cnt <= '0;
          tx_sr    <= tx_load;
          lsb_q    <= lsbfe;
          if (!cpha) mosi <= tx_load[7];
        end
        SHIFT: begin
          if (div_zero) begin
            div_cnt  <= half_m1;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 4'd1;
            if (sample_edge) begin
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              // CPHA=0 already shows bit 7 from LOAD, so trailing edges present the next bit
              mosi  <= cpha ? tx_sr[7] : tx_sr[6];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt - 12'd1;
          end
        end
        default: sclk <= cpol;
      endcase
    end
  end

  // status
  logic       spif, wcol, spi_int_q;
  logic [1:0] xfer_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      spif      <= 1'b0;
      wcol      <= 1'b0;
      xfer_cnt  <= '0;
      spi_int_q <= 1'b0;
    end else begin
      spi_int_q <= spie & spif;
      if (bus.wr_spsr && bus.clear_wcol) wcol <= 1'b0;
      if (wcol_set) wcol <= 1'b1;
      if (bus.wr_spsr && bus.clear_spif) begin
        spif     <= 1'b0;
        xfer_cnt <= '0;
      end
      if (!spe) begin
        xfer_cnt <= '0;
      end else if (state_q == DONE) begin
        if (xfer_cnt == icnt) begin
          spif     <= 1'b1;
          xfer_cnt <= '0;
        end else begin
          xfer_cnt <= xfer_cnt + 2'd1;
        end
      end
    end
  end

  assign bus.rfdout  = rf_empty ? 8'h00 : rf_mem[rf_rd];
  assign bus.spsr    = {spif, wcol, 2'b00, wf_full, wf_empty, rf_full, rf_empty};
  assign bus.spi_int = spi_int_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_engine.sv
// Directed bench for spi_engine: queued expectations checked by rfdout and slave-side monitors.
module tb_spi_engine;

  logic clk, reset, sclk, mosi, miso;
  logic loop, slave_bit;
  logic [7:0] slave_tx;

  spi_engine_if bus();

  spi_engine #(.FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso)
  );

  assign miso = loop ? mosi : slave_bit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int tcyc = 0;
  int rises = 0;
  int viol = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int n);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", name, n);
  endtask

  // rfdout scoreboard: whenever a pop of a non-empty read FIFO is presented
  always @(negedge clk) begin
    if (!reset && bus.rfre && !bus.spsr[0]) begin
      if (exp_rx.size() == 0) timeout("rfdout unexpected data", 0);
      else check("rfdout", 32'(bus.rfdout), 32'(exp_rx.pop_front()));
    end
  end

  // slave model: drives miso, captures mosi, polices mosi change points
  logic [4:0] cnt;
  logic [7:0] cap, tmp;
  logic prev_sclk, prev_mosi, prev_busy, edge_now, samp, allowed;

  always @(negedge clk) begin
    if (reset) begin
      cnt = 0; cap = 0; slave_bit = 0;
      prev_sclk = sclk; prev_mosi = mosi; prev_busy = 0;
    end else begin
      if (sclk && !prev_sclk) rises++;
      edge_now = (sclk != prev_sclk);
      samp = 1'b0;
      if (bus.busy) begin
        if (edge_now) begin
          cnt = cnt + 5'd1;
          samp = bus.spcr[2] ? ~cnt[0] : cnt[0];
          if (samp) cap = {cap[6:0], mosi};
        end
        if (mosi != prev_mosi) begin
          allowed = edge_now ? !samp : (cnt == 0 && !bus.spcr[2]);
          if (!allowed) viol++;
        end
      end
      if (prev_busy && !bus.busy && cnt == 5'd16) begin
        if (exp_tx.size() == 0) timeout("mosi unexpected byte", 0);
        else check("mosi byte", 32'(cap), 32'(exp_tx.pop_front()));
      end
      if (!bus.busy) cnt = 0;
      tmp = slave_tx << cnt[3:1];
      slave_bit = (cnt < 5'd16) ? tmp[7] : 1'b0;
      prev_sclk = sclk; prev_mosi = mosi; prev_busy = bus.busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1; bus.wfwe = 1'b1; bus.wfdin = b;
    @(posedge clk); #1; bus.wfwe = 1'b0;
  endtask

  task automatic pop();
    @(posedge clk); #1; bus.rfre = 1'b1;
    @(posedge clk); #1; bus.rfre = 1'b0;
  endtask

  task automatic spsr_write(input logic wr, input logic cs, input logic cw);
    @(posedge clk); #1; bus.wr_spsr = wr; bus.clear_spif = cs; bus.clear_wcol = cw;
    @(posedge clk); #1; bus.wr_spsr = 0; bus.clear_spif = 0; bus.clear_wcol = 0;
  endtask

  task automatic wait_xfer(input string name, input int budget);
    int n = 0;
    while (!bus.busy && n < budget) begin tick(1); n++; end
    while (bus.busy && n < budget) begin tick(1); n++; end
    if (n >= budget) timeout(name, n);
  endtask

  task automatic wait_sclk(input string name, input logic lvl, input int budget);
    int n = 0;
    while (sclk !== lvl && n < budget) begin tick(1); n++; end
    if (n >= budget) timeout(name, n);
  endtask

  int t0, t1, r0, v0;
  logic [1:0] md;

  initial begin
    reset = 1; loop = 1; slave_tx = 8'h00;
    bus.spcr = 0; bus.sper = 0; bus.wfwe = 0; bus.wfdin = 0; bus.rfre = 0;
    bus.wr_spsr = 0; bus.clear_spif = 0; bus.clear_wcol = 0;
    tick(3);
    reset = 0;
    tick(1);

    // 1: reset state
    check("reset spsr", 32'(bus.spsr), 32'h05);
    check("reset sclk", 32'(sclk), 0);
    check("reset mosi", 32'(mosi), 0);
    check("reset rfdout", 32'(bus.rfdout), 32'h00);
    check("reset spi_int", 32'(bus.spi_int), 0);
    check("reset busy", 32'(bus.busy), 0);

    // 2: mode 0, divide by 2, loopback
    bus.spcr = 8'h50;
    tick(1);
    r0 = rises;
    exp_rx.push_back(8'hA5); exp_tx.push_back(8'hA5);
    push(8'hA5);
    t0 = tcyc;
    wait_sclk("first rise", 1'b1, 50);
    check("first edge latency", tcyc - t0, 3);
    wait_xfer("mode0 xfer", 200);
    check("mode0 rises", rises - r0, 8);
    check("mode0 spif", 32'(bus.spsr[7]), 1);
    pop();
    check("spsr after pop", 32'(bus.spsr), 32'h85);
    spsr_write(1, 1, 0);
    check("spif cleared", 32'(bus.spsr), 32'h05);

    // 3: modes 1-3 against the slave model
    loop = 0; slave_tx = 8'h96;
    for (int m = 1; m < 4; m++) begin
      md = 2'(m);
      bus.spcr = 8'h50 | {4'h0, md, 2'b00};
      tick(2);
      check("sclk idle", 32'(sclk), 32'(md[1]));
      v0 = viol;
      exp_rx.push_back(8'h96); exp_tx.push_back(8'h3C);
      push(8'h3C);
      wait_xfer("mode xfer", 200);
      check("sclk after xfer", 32'(sclk), 32'(md[1]));
      check("mosi edges", viol, v0);
      pop();
      spsr_write(1, 1, 0);
    end

    // 4: ICNT=3, fill write FIFO with master disabled, then run
    loop = 1;
    bus.sper = 8'hC0; bus.spcr = 8'hC0;
    tick(1);
    for (int i = 1; i <= 4; i++) begin
      exp_rx.push_back(8'(i * 8'h11)); exp_tx.push_back(8'(i * 8'h11));
      push(8'(i * 8'h11));
    end
    check("wffull", 32'(bus.spsr[3]), 1);
    check("mstr=0 holds idle", 32'(bus.busy), 0);
    push(8'h55);
    check("wcol on full push", 32'(bus.spsr[6]), 1);
    bus.spcr = 8'hD0;
    for (int k = 1; k <= 4; k++) begin
      wait_xfer("icnt xfer", 200);
      check("spif by count", 32'(bus.spsr[7]), 32'(k == 4));
      check("spi_int lag", 32'(bus.spi_int), 0);
    end
    tick(1);
    check("spi_int set", 32'(bus.spi_int), 1);
    spsr_write(0, 1, 1);
    check("clear without wr_spsr", 32'(bus.spsr), 32'hC6);

    // 6: 5th transfer into a full read FIFO
    exp_tx.push_back(8'h66);
    push(8'h66);
    wait_xfer("overflow xfer", 200);
    check("rf full kept", 32'(bus.spsr), 32'hC6);
    check("rf head oldest", 32'(bus.rfdout), 32'h11);
    repeat (4) pop();
    check("rf drained", 32'(bus.spsr), 32'hC5);
    check("rfdout empty", 32'(bus.rfdout), 32'h00);

    // 5: slowest divider (sel 11 and clamped 15), CPOL=1, abort mid-byte
    for (int j = 0; j < 2; j++) begin
      bus.sper = (j == 0) ? 8'h02 : 8'h03;
      bus.spcr = 8'h5B;
      tick(2);
      check("slow sclk idle", 32'(sclk), 1);
      push(8'hA1);
      t0 = tcyc;
      push(8'hB2);
      wait_sclk("slow edge1", 1'b0, 3000);
      t1 = tcyc;
      check("slow latency", t1 - t0, 2050);
      wait_sclk("slow edge2", 1'b1, 5000);
      wait_sclk("slow edge3", 1'b0, 5000);
      check("slow period", tcyc - t1, 4096);
      bus.spcr = 8'h1B;
      tick(1);
      check("abort sclk", 32'(sclk), 1);
      check("abort busy", 32'(bus.busy), 0);
      check("abort spsr", 32'(bus.spsr), 32'hC5);
      tick(3);
      check("abort no rx push", 32'(bus.spsr), 32'hC5);
      check("abort mosi", 32'(mosi), 0);
    end
    spsr_write(1, 0, 1);
    check("wcol cleared", 32'(bus.spsr), 32'h85);
    spsr_write(1, 1, 0);
    check("all cleared", 32'(bus.spsr), 32'h05);

    tick(2);
    check("rx queue drained", exp_rx.size(), 0);
    check("tx queue drained", exp_tx.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
